// File: rtl/matrix_scan_controller.sv
// -----------------------------------------------------------------------------
// matrix_scan_controller
//
// Time-multiplexed scan sequencer for a 5-column LED matrix whose columns are
// mirrored in pairs (0/4, 1/3, 2). Three column groups are lit one after the
// other. Each group gets an optional all-off blanking gap, then a dwell period
// with its row pattern driven. The shown image is double-buffered. A new image
// is only swapped in at a frame boundary, or while the scanner is idle.
//
// Parameters
//   ROWS          row lines per column
//   DWELL_CYCLES  clocks each column group is lit (>= 1)
//   BLANK_CYCLES  clocks of all-off before each group (0 = no blanking)
//
// Ports
//   clock_i         system clock, rising edge
//   reset_n_i       synchronous reset, active-low
//   enable_i        1 = scan runs, 0 = display dark
//   image_data_i    half-image: [ROWS-1:0] = group0 (cols 0/4),
//                   next ROWS = group1 (cols 1/3), top ROWS = group2 (col 2)
//   image_valid_i   producer offers image_data_i
//   image_ready_o   pending buffer empty; transfer when valid & ready
//   ring_counter_o  one-hot column group select (000 = all off)
//   row_o           row drive for the current group, 1 = LED on
//   frame_done_o    single-cycle pulse after each completed frame
// -----------------------------------------------------------------------------
module matrix_scan_controller #(
  parameter int ROWS         = 7,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              enable_i,
  input  logic [3*ROWS-1:0] image_data_i,
  input  logic              image_valid_i,
  output logic              image_ready_o,
  output logic [2:0]        ring_counter_o,
  output logic [ROWS-1:0]   row_o,
  output logic              frame_done_o
);

  // One counter serves both the blank and the dwell phase. It is sized for
  // the longer of the two.
  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          group_q, group_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          ring_q, ring_d;
  logic [ROWS-1:0]     row_q, row_d;
  logic                frame_done_q, frame_done_d;
  logic [3*ROWS-1:0]   display_q, display_d;
  logic [3*ROWS-1:0]   pending_q, pending_d;
  logic                pending_valid_q, pending_valid_d;
  logic                ready_q, ready_d;

  logic                frame_end;
  logic                swap;
  logic                accept;

  // One-hot column select for a group index. Index 3 is unused and maps to
  // all-off.
  function automatic logic [2:0] group_onehot(input logic [1:0] g);
    case (g)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Row pattern of one column group taken from the packed half-image.
  function automatic logic [ROWS-1:0] group_rows(input logic [3*ROWS-1:0] img,
                                                 input logic [1:0]        g);
    case (g)
      2'd0:    return img[ROWS-1:0];
      2'd1:    return img[2*ROWS-1:ROWS];
      default: return img[3*ROWS-1:2*ROWS];
    endcase
  endfunction

  always_comb begin
    state_d         = state_q;
    group_d         = group_q;
    cnt_d           = cnt_q;
    display_d       = display_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    frame_end       = 1'b0;
    accept          = image_valid_i & ~pending_valid_q;

    case (state_q)
      ST_IDLE: begin
        group_d = 2'd0;
        cnt_d   = '0;
        if (enable_i) begin
          state_d = HAS_BLANK ? ST_BLANK : ST_DRIVE;
        end
      end
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = ST_DRIVE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d   = '0;
          state_d = HAS_BLANK ? ST_BLANK : ST_DRIVE;
          if (group_q == 2'd2) begin
            group_d   = 2'd0;
            frame_end = 1'b1;
          end else begin
            group_d = group_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        group_d = 2'd0;
        cnt_d   = '0;
      end
    endcase

    // Disable wins over every scan transition. A frame cut short this way
    // does not count as completed.
    if (!enable_i) begin
      state_d   = ST_IDLE;
      group_d   = 2'd0;
      cnt_d     = '0;
      frame_end = 1'b0;
    end

    // The displayed image only changes where it cannot tear a frame: at the
    // frame boundary, or while the scanner is dark.
    swap = pending_valid_q & (frame_end | (state_q == ST_IDLE));

    // swap needs a full pending buffer and accept needs an empty one, so the
    // two never coincide.
    if (swap) begin
      display_d       = pending_q;
      pending_valid_d = 1'b0;
    end else if (accept) begin
      pending_d       = image_data_i;
      pending_valid_d = 1'b1;
    end

    // Outputs are decoded from next-state values so the registered pins line
    // up exactly with the registered state.
    frame_done_d = frame_end;
    ready_d      = ~pending_valid_d;
    if (state_d == ST_DRIVE) begin
      ring_d = group_onehot(group_d);
      row_d  = group_rows(display_d, group_d);
    end else begin
      ring_d = 3'b000;
      row_d  = '0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q         <= ST_IDLE;
      group_q         <= 2'd0;
      cnt_q           <= '0;
      ring_q          <= 3'b000;
      row_q           <= '0;
      frame_done_q    <= 1'b0;
      display_q       <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      ready_q         <= 1'b1;
    end else begin
      state_q         <= state_d;
      group_q         <= group_d;
      cnt_q           <= cnt_d;
      ring_q          <= ring_d;
      row_q           <= row_d;
      frame_done_q    <= frame_done_d;
      display_q       <= display_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      ready_q         <= ready_d;
    end
  end

  assign image_ready_o  = ready_q;
  assign ring_counter_o = ring_q;
  assign row_o          = row_q;
  assign frame_done_o   = frame_done_q;

endmodule
